// File: rtl/switch_debounce_sync.sv
// Switch/button conditioner: 2-FF synchronizer, per-bit counter debounce,
// registered one-cycle rise/fall pulses. Optional sticky edge flags with an
// interrupt output are built when SW_EDGE_IRQ_EN is defined.
module switch_debounce_sync #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
`ifdef SW_EDGE_IRQ_EN
  ,
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0]            state_q, state_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic                        changed_q, changed_d;

  // Two-flop synchronizer for the asynchronous switch pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce FSM; the first mismatching cycle already counts as one,
  // so the counter saturates at DEBOUNCE_CYCLES-1 and never wraps
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case (state_q[i])
        ST_STABLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i] != stable_q[i]) begin
            state_d[i] = ST_COUNTING;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ST_COUNTING: begin
          if (sync2_q[i] == stable_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]  = ST_STABLE;
            cnt_d[i]    = '0;
            stable_d[i] = sync2_q[i];
            rise_d[i]   = sync2_q[i];
            fall_d[i]   = ~sync2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
    changed_d = |(rise_d | fall_d);
  end

  // Debounce state, accepted level and pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign sw_stable  = stable_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign sw_changed = changed_q;

`ifdef SW_EDGE_IRQ_EN
  logic [WIDTH-1:0] capture_q, capture_d;
  logic             irq_q, irq_d;

  // Sticky edge flags: a new pulse beats a simultaneous clear
  always_comb begin
    capture_d = (capture_q & ~edge_clear) | rise_q | fall_q;
    irq_d     = |capture_q;
  end

  // Edge flag and interrupt registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      capture_q <= capture_d;
      irq_q     <= irq_d;
    end
  end

  assign edge_capture = capture_q;
  assign irq          = irq_q;
`endif

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Self-checking bench for switch_debounce_sync (WIDTH=8, DEBOUNCE_CYCLES=4).
// Build with SW_EDGE_IRQ_EN defined to also cover the edge-capture/irq logic.
module tb_switch_debounce_sync;

  localparam int unsigned W  = 8;
  localparam int unsigned DC = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic         sw_changed;
  logic [W-1:0] clr = '0;
`ifdef SW_EDGE_IRQ_EN
  logic [W-1:0] edge_capture;
  logic         irq;
`endif

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int rise3_cnt = 0;

  switch_debounce_sync #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .sw_stable  (sw_stable),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
`ifdef SW_EDGE_IRQ_EN
    ,
    .edge_clear   (clr),
    .edge_capture (edge_capture),
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a bit is accepted once the synchronized input has
  // disagreed with the accepted level for DC consecutive clock edges.
  logic [W-1:0] m_stable = '0, m_rise = '0, m_fall = '0, m_cap = '0;
  logic         m_changed = 1'b0, m_irq = 1'b0;
  int           run [W];
  logic [W-1:0] hist [$];

  always @(posedge clk or negedge reset_n) begin
    logic [W-1:0] obs, old_pulse, old_cap;
    if (!reset_n) begin
      hist = {};
      m_stable = '0; m_rise = '0; m_fall = '0; m_cap = '0;
      m_changed = 1'b0; m_irq = 1'b0;
      for (int i = 0; i < int'(W); i++) run[i] = 0;
    end else begin
      old_pulse = m_rise | m_fall;
      old_cap   = m_cap;
      // value seen downstream of the synchronizer is the one sampled two edges ago
      obs = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
      hist.push_back(sw_raw);
      if (hist.size() > 4) void'(hist.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < int'(W); i++) begin
        if (obs[i] != m_stable[i]) begin
          run[i]++;
          if (run[i] == int'(DC)) begin
            m_stable[i] = obs[i];
            if (obs[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_changed = (m_rise | m_fall) != '0;
      m_cap = (old_cap & ~clr) | old_pulse;
      m_irq = old_cap != '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model_stable",  32'(sw_stable),  32'(m_stable));
    chk("model_rise",    32'(sw_rise),    32'(m_rise));
    chk("model_fall",    32'(sw_fall),    32'(m_fall));
    chk("model_changed", 32'(sw_changed), 32'(m_changed));
`ifdef SW_EDGE_IRQ_EN
    chk("model_capture", 32'(edge_capture), 32'(m_cap));
    chk("model_irq",     32'(irq),          32'(m_irq));
`endif
  endtask

  // advance n cycles, sampling and checking at each falling edge
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_model();
      if (sw_changed) pulse_cnt++;
      if (sw_rise[3]) rise3_cnt++;
    end
  endtask

  initial begin
    logic [W-1:0] hold_val;

    // 1: reset with pins high, then release and hold
    reset_n = 1'b0;
    sw_raw  = 8'hFF;
    step(3);
    chk("reset_stable",  32'(sw_stable),  32'h0);
    chk("reset_rise",    32'(sw_rise),    32'h0);
    chk("reset_changed", 32'(sw_changed), 32'h0);
    reset_n = 1'b1;
    step(5);
    chk("t1_stable_e5", 32'(sw_stable), 32'h00);
    step(1);
    chk("t1_stable_e6", 32'(sw_stable), 32'hFF);
    chk("t1_rise_e6",   32'(sw_rise),   32'hFF);
    chk("t1_chg_e6",    32'(sw_changed), 32'h1);
    step(1);
    chk("t1_rise_e7",   32'(sw_rise),   32'h00);
    chk("t1_chg_e7",    32'(sw_changed), 32'h0);

    // 2: bit0 bounce every two cycles, then hold high
    sw_raw = 8'h00;
    step(10);
    pulse_cnt = 0;
    for (int t = 0; t < 5; t++) begin
      sw_raw[0] = 1'b1; step(2);
      sw_raw[0] = 1'b0; step(2);
    end
    chk("t2_glitch_stable", 32'(sw_stable), 32'h00);
    chk("t2_glitch_pulses", 32'(pulse_cnt), 32'd0);
    sw_raw = 8'h01;
    step(5);
    chk("t2_bit0_e5", 32'(sw_stable[0]), 32'h0);
    step(1);
    chk("t2_bit0_e6", 32'(sw_stable[0]), 32'h1);
    chk("t2_rise_e6", 32'(sw_rise), 32'h01);

    // 3: simultaneous rise and fall on different bits
    sw_raw = 8'h0F;
    step(10);
    sw_raw = 8'hF0;
    step(6);
    chk("t3_stable", 32'(sw_stable), 32'hF0);
    chk("t3_rise",   32'(sw_rise),   32'hF0);
    chk("t3_fall",   32'(sw_fall),   32'h0F);
    chk("t3_chg",    32'(sw_changed), 32'h1);

    // 4: reset in the middle of a bit3 count
    sw_raw = 8'hF8;
    step(4);
    chk("t4_bit3_precount", 32'(sw_stable[3]), 32'h0);
    reset_n = 1'b0;
    step(1);
    chk("t4_in_reset", 32'(sw_stable), 32'h00);
    step(2);
    chk("t4_bit3_reset", 32'(sw_stable[3]), 32'h0);
    reset_n = 1'b1;
    rise3_cnt = 0;
    step(5);
    chk("t4_bit3_e5", 32'(sw_stable[3]), 32'h0);
    step(1);
    chk("t4_bit3_e6",  32'(sw_stable[3]), 32'h1);
    chk("t4_stable_e6", 32'(sw_stable),   32'hF8);
    step(5);
    chk("t4_rise3_count", 32'(rise3_cnt), 32'd1);

`ifdef SW_EDGE_IRQ_EN
    // 5: sticky edge flags, set-beats-clear, and interrupt timing
    clr = 8'hFF; step(1);
    clr = 8'h00; step(2);
    chk("t5_cleared", 32'(edge_capture), 32'h00);
    sw_raw = 8'hFC;
    step(6);
    chk("t5_rise2", 32'(sw_rise), 32'h04);
    step(1);
    chk("t5_cap_set", 32'(edge_capture), 32'h04);
    step(1);
    chk("t5_irq_set", 32'(irq), 32'h1);
    sw_raw = 8'hF8;
    step(6);
    chk("t5_fall2", 32'(sw_fall), 32'h04);
    clr = 8'h04; step(1);
    chk("t5_set_wins", 32'(edge_capture), 32'h04);
    clr = 8'h00; step(1);
    clr = 8'h04; step(1);
    chk("t5_cap_clr", 32'(edge_capture), 32'h00);
    clr = 8'h00; step(1);
    chk("t5_irq_clr", 32'(irq), 32'h0);
`endif

    // randomized bouncing against the model
    for (int r = 0; r < 120; r++) begin
      sw_raw = W'($urandom);
      step(int'($urandom_range(1, 6)));
    end

    // 6: long constant hold after settling
    hold_val = W'($urandom);
    sw_raw = hold_val;
    step(10);
    pulse_cnt = 0;
    step(1000);
    chk("t6_pulses", 32'(pulse_cnt), 32'd0);
    chk("t6_stable", 32'(sw_stable), 32'(hold_val));
    for (int i = 0; i < int'(W); i++)
      chk("t6_counter", 32'(dut.cnt_q[i]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
